// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Registered program counter for the head of the fetch path. It replaces a
// bare PC+4 adder with next-PC selection for conditional branch, absolute
// jump and register jump. It also keeps a small circular return-address
// stack (RAS) that call/return sequences push and pop.
//
// Parameters
//   WIDTH      PC width in bits (>= 32)
//   RESET_PC   PC value loaded while rst_n is low
//   STEP       sequential increment in bytes
//   RAS_DEPTH  number of return-address entries (2..16)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          freeze PC and RAS; every other control is ignored
//   branch_taken   take the conditional branch this cycle
//   branch_offset  signed word offset, relative to pc_plus_step
//   jump           absolute jump (J/JAL)
//   jump_index     26-bit word index for the jump target
//   jr             register jump
//   jr_target      register-jump byte address
//   call           push pc_plus_step onto the RAS
//   ret            together with jr: return through the RAS top if non-empty
//   pc             current PC (registered)
//   pc_plus_step   pc + STEP (combinational)
//   ras_count      number of valid RAS entries (registered)
//   ras_underflow  one-cycle pulse after a return on an empty RAS
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned      STEP      = 4,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [15:0]                    branch_offset,
  input  logic                           jump,
  input  logic [25:0]                    jump_index,
  input  logic                           jr,
  input  logic [WIDTH-1:0]               jr_target,
  input  logic                           call,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus_step,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_underflow
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  localparam logic [CW-1:0] COUNT_FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RAS_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    ras_count_q, ras_count_d;
  logic [PW-1:0]    ras_top_q, ras_top_d;
  logic             ras_underflow_q, ras_underflow_d;

  // Return-address storage. Contents are meaningless until pushed, so the
  // array carries no reset and only ras_count decides what is valid.
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  // ---------------------------------------------------------------------------
  // Target computation
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] branch_disp;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] jr_raw;
  logic [WIDTH-1:0] jr_final;
  logic [WIDTH-1:0] ras_top_value;
  logic             ras_nonempty;

  assign step_w       = WIDTH'(STEP);
  assign pc_plus_step = pc_q + step_w;

  // Word offset: sign-extend, then scale to bytes.
  assign branch_disp   = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target = pc_plus_step + branch_disp;

  // Upper region bits come from the sequential address, not the current PC.
  assign jump_target = {pc_plus_step[WIDTH-1:28], jump_index, 2'b00};

  assign ras_nonempty  = (ras_count_q != '0);
  assign ras_top_value = ras_mem_q[ras_top_q];

  assign jr_raw   = (ret && ras_nonempty) ? ras_top_value : jr_target;
  assign jr_final = {jr_raw[WIDTH-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // RAS control
  // ---------------------------------------------------------------------------
  logic             do_pop;
  logic             do_push;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             ras_we;
  logic [PW-1:0]    ras_wr_ptr;

  assign do_pop  = !stall && jr && ret && ras_nonempty;
  assign do_push = !stall && call;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign ptr_inc = (ras_top_q == PTR_LAST) ? '0 : ras_top_q + 1'b1;
  assign ptr_dec = (ras_top_q == '0) ? PTR_LAST : ras_top_q - 1'b1;

  always_comb begin
    ras_top_d       = ras_top_q;
    ras_count_d     = ras_count_q;
    ras_we          = 1'b0;
    ras_wr_ptr      = ras_top_q;
    ras_underflow_d = !stall && jr && ret && !ras_nonempty;

    if (do_pop && do_push) begin
      // The pop has already read the old top through jr_final; the new
      // return address simply replaces that slot.
      ras_we     = 1'b1;
      ras_wr_ptr = ras_top_q;
    end else if (do_push) begin
      // Advancing onto the oldest slot when full overwrites it.
      ras_we     = 1'b1;
      ras_wr_ptr = ptr_inc;
      ras_top_d  = ptr_inc;
      if (ras_count_q != COUNT_FULL) begin
        ras_count_d = ras_count_q + 1'b1;
      end
    end else if (do_pop) begin
      ras_top_d   = ptr_dec;
      ras_count_d = ras_count_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-PC selection (stall > jr > jump > branch > sequential)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_plus_step;
    if (stall) begin
      pc_d = pc_q;
    end else if (jr) begin
      pc_d = jr_final;
    end else if (jump) begin
      pc_d = jump_target;
    end else if (branch_taken) begin
      pc_d = branch_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      ras_count_q     <= '0;
      ras_top_q       <= '0;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ras_count_q     <= ras_count_d;
      ras_top_q       <= ras_top_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  // Writes during reset are harmless: the count is held at zero, so any
  // slot written then is never read as valid.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem_q[ras_wr_ptr] <= pc_plus_step;
    end
  end

  assign pc            = pc_q;
  assign ras_count     = ras_count_q;
  assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer with RESET_PC=0x00400000, STEP=4,
// RAS_DEPTH=4. One linear sequence of steps; expected values are written
// out by hand from the behaviour of the unit.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int unsigned      WIDTH     = 32;
  localparam logic [WIDTH-1:0] RESET_PC  = 32'h0040_0000;
  localparam int unsigned      STEP      = 4;
  localparam int unsigned      RAS_DEPTH = 4;
  localparam int unsigned      CW        = $clog2(RAS_DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             branch_taken;
  logic [15:0]      branch_offset;
  logic             jump;
  logic [25:0]      jump_index;
  logic             jr;
  logic [WIDTH-1:0] jr_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic [CW-1:0]    ras_count;
  logic             ras_underflow;

  int tests_run  = 0;
  int tests_fail = 0;

  pc_sequencer #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .STEP     (STEP),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .call         (call),
    .ret          (ret),
    .pc           (pc),
    .pc_plus_step (pc_plus_step),
    .ras_count    (ras_count),
    .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) begin
      $display("[TB] %-14s ok   obs=0x%08h", tag, obs);
    end else begin
      tests_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 16'h0000;
    jump          = 1'b0;
    jump_index    = 26'h0;
    jr            = 1'b0;
    jr_target     = '0;
    call          = 1'b0;
    ret           = 1'b0;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_ctl();
    rst_n = 1'b0;
    #12;
    check("rst_pc",    pc, RESET_PC);
    check("rst_cnt",   32'(ras_count), 32'd0);
    check("rst_uf",    32'(ras_underflow), 32'd0);
    check("rst_pps",   pc_plus_step, 32'h0040_0004);
    rst_n = 1'b1;

    // Sequential
    cyc(); check("seq1", pc, 32'h0040_0004);
    cyc(); check("seq2", pc, 32'h0040_0008);
    cyc(); check("seq3", pc, 32'h0040_000C);
    check("seq_cnt", 32'(ras_count), 32'd0);
    cyc(); check("seq4", pc, 32'h0040_0010);

    // Branch backward: 0x14 + (-2 << 2)
    branch_taken = 1'b1; branch_offset = 16'hFFFE;
    cyc(); check("br_back", pc, 32'h0040_000C);
    clear_ctl();
    cyc(); check("seq5", pc, 32'h0040_0010);
    // Branch forward: 0x14 + (3 << 2)
    branch_taken = 1'b1; branch_offset = 16'h0003;
    cyc(); check("br_fwd", pc, 32'h0040_0020);
    clear_ctl();

    // Move to 0x10000000 and test priority
    jr = 1'b1; jr_target = 32'h1000_0000;
    cyc(); check("jr_move", pc, 32'h1000_0000);
    clear_ctl();
    jump = 1'b1; jump_index = 26'h0000040; branch_taken = 1'b1; branch_offset = 16'h0010;
    cyc(); check("jmp_over_br", pc, 32'h1000_0100);
    jr = 1'b1; jr_target = 32'h0000_0123;
    cyc(); check("jr_over_jmp", pc, 32'h0000_0120);
    clear_ctl();

    // Call/return
    jr = 1'b1; jr_target = 32'h0040_0000;
    cyc(); check("jr_move2", pc, 32'h0040_0000);
    clear_ctl();
    call = 1'b1; jump = 1'b1; jump_index = 26'h0100100;
    cyc(); check("call_pc", pc, 32'h0040_0400);
    check("call_cnt", 32'(ras_count), 32'd1);
    clear_ctl();
    ret = 1'b1; jr = 1'b1; jr_target = 32'h0;
    cyc(); check("ret_pc", pc, 32'h0040_0004);
    check("ret_cnt", 32'(ras_count), 32'd0);
    check("ret_uf", 32'(ras_underflow), 32'd0);
    cyc(); check("uf_pc", pc, 32'h0000_0000);
    check("uf_pulse", 32'(ras_underflow), 32'd1);
    check("uf_cnt", 32'(ras_count), 32'd0);
    clear_ctl();
    cyc(); check("uf_clear", 32'(ras_underflow), 32'd0);
    check("uf_seq", pc, 32'h0000_0004);

    // Overflow: pushes of 8, C, 10, 14, 18 from sequential calls
    call = 1'b1;
    cyc(); check("push1_cnt", 32'(ras_count), 32'd1);
    cyc(); check("push2_cnt", 32'(ras_count), 32'd2);
    cyc(); check("push3_cnt", 32'(ras_count), 32'd3);
    cyc(); check("push4_cnt", 32'(ras_count), 32'd4);
    cyc(); check("push5_cnt", 32'(ras_count), 32'd4);
    check("push_pc", pc, 32'h0000_0018);
    clear_ctl();
    // ret without jr leaves the RAS alone
    ret = 1'b1;
    cyc(); check("ret_nojr_cnt", 32'(ras_count), 32'd4);
    check("ret_nojr_pc", pc, 32'h0000_001C);
    jr = 1'b1; jr_target = 32'h0FFF_FFF0;
    cyc(); check("pop_e", pc, 32'h0000_0018); check("pop_e_cnt", 32'(ras_count), 32'd3);
    cyc(); check("pop_d", pc, 32'h0000_0014); check("pop_d_cnt", 32'(ras_count), 32'd2);
    cyc(); check("pop_c", pc, 32'h0000_0010); check("pop_c_cnt", 32'(ras_count), 32'd1);
    cyc(); check("pop_b", pc, 32'h0000_000C); check("pop_b_cnt", 32'(ras_count), 32'd0);
    // Empty: jr_target used with low bits cleared
    jr_target = 32'h0000_0FF3;
    cyc(); check("pop_empty", pc, 32'h0000_0FF0);
    check("pop_empty_uf", 32'(ras_underflow), 32'd1);
    clear_ctl();

    // Simultaneous pop and push
    call = 1'b1;
    cyc(); check("pp_push_cnt", 32'(ras_count), 32'd1);
    check("pp_push_pc", pc, 32'h0000_0FF4);
    ret = 1'b1; jr = 1'b1; jr_target = 32'h0000_0800;
    cyc(); check("pp_pc", pc, 32'h0000_0FF4);
    check("pp_cnt", 32'(ras_count), 32'd1);
    call = 1'b0;
    cyc(); check("pp_ret_pc", pc, 32'h0000_0FF8);
    check("pp_ret_cnt", 32'(ras_count), 32'd0);

    // Underflow followed by stall: stall clears the pulse and freezes pc/RAS
    jr_target = 32'h0000_0040;
    cyc(); check("st_pre_uf", 32'(ras_underflow), 32'd1);
    check("st_pre_pc", pc, 32'h0000_0040);
    stall = 1'b1; jump = 1'b1; jump_index = 26'h0000100; call = 1'b1;
    cyc(); check("st1_pc", pc, 32'h0000_0040);
    check("st1_cnt", 32'(ras_count), 32'd0);
    check("st1_uf", 32'(ras_underflow), 32'd0);
    cyc(); check("st2_pc", pc, 32'h0000_0040);
    check("st2_cnt", 32'(ras_count), 32'd0);
    clear_ctl();

    // Wrap
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    cyc(); check("wrap_pre", pc, 32'hFFFF_FFFC);
    check("wrap_pps", pc_plus_step, 32'h0000_0000);
    clear_ctl();
    cyc(); check("wrap_pc", pc, 32'h0000_0000);

    // Asynchronous reset between edges, with a push in the RAS
    call = 1'b1;
    cyc(); check("ar_pre_cnt", 32'(ras_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_pc", pc, RESET_PC);
    check("ar_cnt", 32'(ras_count), 32'd0);
    clear_ctl();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); check("ar_resume", pc, 32'h0040_0004);
    check("ar_resume_cnt", 32'(ras_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
